// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants and state encoding for the sprite OAM DMA engine.
// Bus widths, trigger/destination addresses and transfer length live here.
package oam_dma_ctrl_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;
    localparam int XFER_LEN   = 256;

    localparam logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: snoops a CPU write to $4014, stalls the CPU and
// copies one 256-byte page to OAMDATA, one read/write pair per byte.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_dout,
    input  logic                  cpu_rw_n,
    input  logic [REG_WIDTH-1:0]  mem_din,
    output logic                  rdy,
    output logic                  dma_active,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [REG_WIDTH-1:0]  bus_dout,
    output logic                  bus_rw_n
);

    dma_state_e           state_q, state_d;
    logic [7:0]           page_q, page_d;
    logic [7:0]           idx_q, idx_d;
    logic [REG_WIDTH-1:0] latch_q, latch_d;
    logic                 parity_q;

    logic trigger;
    assign trigger = (cpu_addr == DMA_REG_ADDR) && !cpu_rw_n;

    // State and counter registers; parity free-runs to find the read-aligned cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            latch_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
            parity_q <= ~parity_q;
        end
    end

    // Next-state sequencing; the trigger is only honoured while idle.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        latch_d = latch_q;
        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    page_d  = cpu_dout;
                    idx_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                state_d = parity_q ? S_ALIGN : S_READ;
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                latch_d = mem_din;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs decoded from registered state; idle values match reset.
    always_comb begin
        rdy        = 1'b1;
        dma_active = 1'b0;
        bus_addr   = '0;
        bus_dout   = '0;
        bus_rw_n   = 1'b1;
        unique case (state_q)
            S_IDLE: begin
            end
            S_HALT, S_ALIGN: begin
                rdy        = 1'b0;
                dma_active = 1'b1;
            end
            S_READ: begin
                rdy        = 1'b0;
                dma_active = 1'b1;
                bus_addr   = {page_q, idx_q};
            end
            S_WRITE: begin
                rdy        = 1'b0;
                dma_active = 1'b1;
                bus_addr   = OAM_DATA_ADDR;
                bus_dout   = latch_q;
                bus_rw_n   = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl against a byte-array memory model.
// Checks stall length, read sequence and OAM write stream per transfer.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw_n;
    logic [7:0]  mem_din;
    logic        rdy;
    logic        dma_active;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_rw_n;

    logic [7:0] mem [0:65535];
    logic       par_m;
    int         vec;
    int         errs;

    assign mem_din = mem[bus_addr];

    oam_dma_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_rw_n   (cpu_rw_n),
        .mem_din    (mem_din),
        .rdy        (rdy),
        .dma_active (dma_active),
        .bus_addr   (bus_addr),
        .bus_dout   (bus_dout),
        .bus_rw_n   (bus_rw_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parity reference: 0 on the first edge after reset, toggling each edge.
    always @(posedge clk) par_m <= reset ? 1'b0 : ~par_m;

    task automatic bus_idle();
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        cpu_rw_n = 1'b1;
    endtask

    task automatic check_idle(input string name);
        vec++;
        if (rdy !== 1'b1 || dma_active !== 1'b0 || bus_addr !== 16'h0 ||
            bus_dout !== 8'h0 || bus_rw_n !== 1'b1) begin
            errs++;
            $display("FAIL %s: rdy=%b act=%b addr=%h dout=%h rw=%b want 1 0 0000 00 1",
                     name, rdy, dma_active, bus_addr, bus_dout, bus_rw_n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_idle("after_reset");
    endtask

    task automatic run_dma(input logic [7:0] page, input bit align,
                           input bit retrig, input bit abort);
        int  len, ridx, widx, pre;
        bit  done;
        logic [15:0] ea;
        len = 0; ridx = 0; widx = 0; done = 0;
        pre = align ? 2 : 1;
        @(negedge clk);
        if (par_m !== (align ? 1'b0 : 1'b1)) @(negedge clk);
        cpu_addr = 16'h4014;
        cpu_rw_n = 1'b0;
        cpu_dout = page;
        @(posedge clk);
        #1;
        if (retrig) cpu_dout = 8'h03;
        else bus_idle();
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                done = 1;
            end else begin
                len++;
                vec++;
                if (dma_active !== 1'b1) begin
                    errs++;
                    $display("FAIL active: got %b want 1 (cycle %0d)", dma_active, len);
                end
                vec++;
                if (len <= pre) begin
                    if (bus_addr !== 16'h0 || bus_rw_n !== 1'b1) begin
                        errs++;
                        $display("FAIL halt_bus: addr=%h rw=%b want 0000 1", bus_addr, bus_rw_n);
                    end
                end else if (bus_rw_n === 1'b0) begin
                    ea = {page, 8'(widx)};
                    if (bus_addr !== 16'h2004 || bus_dout !== mem[ea] || ridx != widx + 1) begin
                        errs++;
                        $display("FAIL oam_write %0d: addr=%h dout=%h want 2004 %h",
                                 widx, bus_addr, bus_dout, mem[ea]);
                    end
                    if (abort && widx == 8'h40) begin
                        reset = 1'b1;
                        @(posedge clk);
                        #1;
                        reset = 1'b0;
                        @(negedge clk);
                        check_idle("abort");
                        done = 1;
                    end
                    widx++;
                end else begin
                    ea = {page, 8'(ridx)};
                    if (bus_addr !== ea || ridx != widx) begin
                        errs++;
                        $display("FAIL src_read %0d: addr=%h want %h", ridx, bus_addr, ea);
                    end
                    ridx++;
                end
            end
        end
        if (retrig) bus_idle();
        vec++;
        if (!done) begin
            errs++;
            $display("FAIL timeout: stall still active after 600 cycles");
        end
        if (!abort) begin
            vec++;
            if (len != 512 + pre || widx != 256 || ridx != 256) begin
                errs++;
                $display("FAIL length page %h: len=%0d r=%0d w=%0d want %0d 256 256",
                         page, len, ridx, widx, 512 + pre);
            end
        end
        check_idle("end_idle");
        @(negedge clk);
        check_idle("end_idle2");
    endtask

    task automatic test_even_odd();
        run_dma(8'h02, 1'b0, 1'b0, 1'b0);
        run_dma(8'h02, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_page_ff();
        run_dma(8'hFF, 1'b0, 1'b0, 1'b0);
        run_dma(8'hFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_retrigger();
        run_dma(8'h02, 1'b0, 1'b1, 1'b0);
        run_dma(8'h02, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midop();
        run_dma(8'h02, 1'(($urandom) & 1), 1'b0, 1'b1);
        run_dma(8'h02, 1'(($urandom) & 1), 1'b0, 1'b0);
    endtask

    task automatic test_non_trigger();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                cpu_addr = 16'h4014;
                cpu_rw_n = 1'b1;
            end else begin
                cpu_addr = 16'h4015;
                cpu_rw_n = 1'b0;
            end
            cpu_dout = 8'($urandom);
            @(negedge clk);
            check_idle("non_trigger");
        end
        bus_idle();
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = 16'($urandom);
            if (a == 16'h4014) a = 16'h4013;
            cpu_addr = a;
            cpu_rw_n = 1'($urandom);
            cpu_dout = 8'($urandom);
            @(negedge clk);
            check_idle("rand_bus");
        end
        bus_idle();
        for (int i = 0; i < 4; i++) begin
            run_dma(8'($urandom), 1'(($urandom) & 1), 1'(($urandom) & 1), 1'b0);
        end
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_non_trigger();
        test_even_odd();
        test_page_ff();
        test_retrigger();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
